// File: rtl/tlul_pkg.sv
// TL-UL channel bundles and opcodes shared by the crossbar and its devices.
package tlul_pkg;

  localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
  localparam logic [2:0] GET              = 3'h4;
  localparam logic [2:0] ACCESS_ACK       = 3'h0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [3:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/uart_lite_pkg.sv
// Register map, status layout and serializer states of the UART lite device.
package uart_lite_pkg;

  localparam int DIV_W = 16;

  localparam logic [11:0] TXDATA_OFF = 12'h0;
  localparam logic [11:0] STATUS_OFF = 12'h4;
  localparam logic [11:0] BAUD_OFF   = 12'h8;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_e;

endpackage

// File: rtl/uart_lite_tx_ser.sv
// 8N1 serializer: pops one byte in IDLE, then start, 8 data bits LSB first, stop.
module uart_lite_tx_ser
  import uart_lite_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             tx_o,
  output logic             busy_o
);

  ser_state_e       state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             tx_q;
  logic             bit_end;

  assign bit_end = (cnt == div_q - DIV_W'(1));

  // div_q is re-sampled at every bit start so divider writes land on a boundary
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      div_q   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      cnt <= cnt + DIV_W'(1);
      unique case (state)
        S_IDLE: begin
          tx_q <= 1'b1;
          cnt  <= '0;
          if (valid_i) begin
            shreg <= data_i;
            div_q <= div_i;
            tx_q  <= 1'b0;
            state <= S_START;
          end
        end
        S_START: if (bit_end) begin
          cnt     <= '0;
          div_q   <= div_i;
          bit_cnt <= '0;
          tx_q    <= shreg[0];
          state   <= S_DATA;
        end
        S_DATA: if (bit_end) begin
          cnt   <= '0;
          div_q <= div_i;
          if (bit_cnt == 3'd7) begin
            tx_q  <= 1'b1;
            state <= S_STOP;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= shreg >> 1;
            tx_q    <= shreg[1];
          end
        end
        S_STOP: if (bit_end) begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready_o = (state == S_IDLE);
  assign busy_o  = (state != S_IDLE);
  assign tx_o    = tx_q;

endmodule

// File: rtl/tlul_uart_lite.sv
// TL-UL write-only UART: register front end, TX FIFO and baud divider.
module tlul_uart_lite
  import tlul_pkg::*;
  import uart_lite_pkg::*;
#(
  parameter int               FIFO_DEPTH = 4,
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd868,
  parameter int               ADDR_W     = 12
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o,
  output logic    tx_o,
  output logic    tx_busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             full, empty, push, pop;
  logic             ser_ready, ser_busy;
  logic [DIV_W-1:0] baud;

  logic             rsp_pending;
  logic [2:0]       rsp_opcode;
  logic [1:0]       rsp_size;
  logic [7:0]       rsp_source;
  logic [31:0]      rsp_data;
  logic             rsp_error;

  logic             accept, is_get, is_put;
  logic             hit_tx, hit_st, hit_bd;
  logic             err_c, baud_we;
  logic [31:0]      data_c;
  logic [DIV_W-1:0] baud_new;
  logic [ADDR_W-1:0] off;
  logic [2:0]       status;

  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  assign status = {ser_busy, empty, full};
  assign accept = tl_i.a_valid && !rsp_pending;
  assign off    = {tl_i.a_address[ADDR_W-1:2], 2'b00};
  assign is_get = (tl_i.a_opcode == GET);
  assign is_put = (tl_i.a_opcode == PUT_FULL_DATA) ||
                  (tl_i.a_opcode == PUT_PARTIAL_DATA);
  assign hit_tx = (off == ADDR_W'(TXDATA_OFF));
  assign hit_st = (off == ADDR_W'(STATUS_OFF));
  assign hit_bd = (off == ADDR_W'(BAUD_OFF));

  always_comb begin
    err_c  = !(is_get || is_put) || !(hit_tx || hit_st || hit_bd) ||
             (is_put && hit_tx && tl_i.a_mask[0] && full);
    data_c = '0;
    if (!err_c && is_get && hit_st) data_c = {29'b0, status};
    if (!err_c && is_get && hit_bd) data_c = {16'b0, baud};
  end

  assign push    = accept && is_put && hit_tx && tl_i.a_mask[0] && !full;
  assign baud_we = accept && is_put && hit_bd;
  assign pop     = ser_ready && !empty;

  always_comb begin
    baud_new = baud;
    if (tl_i.a_mask[0]) baud_new[7:0]  = tl_i.a_data[7:0];
    if (tl_i.a_mask[1]) baud_new[15:8] = tl_i.a_data[15:8];
    if (baud_new == '0) baud_new = DIV_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_pending <= 1'b0;
      rsp_opcode  <= '0;
      rsp_size    <= '0;
      rsp_source  <= '0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
      baud        <= DIV_RESET;
    end else begin
      if (accept) begin
        rsp_pending <= 1'b1;
        rsp_opcode  <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        rsp_size    <= tl_i.a_size;
        rsp_source  <= tl_i.a_source;
        rsp_data    <= data_c;
        rsp_error   <= err_c;
      end else if (tl_i.d_ready) begin
        rsp_pending <= 1'b0;
      end
      if (baud_we) baud <= baud_new;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= tl_i.a_data[7:0];
  end

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = !rsp_pending;
    tl_o.d_valid  = rsp_pending;
    tl_o.d_opcode = rsp_opcode;
    tl_o.d_size   = rsp_size;
    tl_o.d_source = rsp_source;
    tl_o.d_data   = rsp_data;
    tl_o.d_error  = rsp_error;
  end

  uart_lite_tx_ser u_ser (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .div_i   (baud),
    .data_i  (mem[rptr]),
    .valid_i (!empty),
    .ready_o (ser_ready),
    .tx_o    (tx_o),
    .busy_o  (ser_busy)
  );

  assign tx_busy_o = ser_busy || !empty;

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:ADDR_W],
                       tl_i.a_address[1:0], tl_i.a_data[31:16],
                       tl_i.a_mask[3:2]};

endmodule
